tao_seq: RTL and testbench
==========================

# tao_seq

Multi-cycle instruction sequencer for the tao core. It owns the PC and instruction register and runs the fetch handshake to instruction memory. It presents the latched instruction to `tao_decode`, stalls on load/store through the LSU handshake, and issues the single-cycle register-file write strobe and PC update. It halts on ebreak, on a handshake timeout, or on a misaligned jump target.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.
- `TIMEOUT`, 255, maximum wait cycles in any handshake state before an error halt (1..65535).

Ports:
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `ifu_req_valid` out 1: fetch request.
- `ifu_req_ready` in 1: instruction memory accepts the request.
- `ifu_req_addr` out 32: fetch address; always equals `o_pc`.
- `ifu_rsp_valid` in 1: instruction return.
- `ifu_rsp_inst` in 32: returned instruction.
- `o_inst` out 32: instruction register, feeds `tao_decode.i_inst`.
- `o_pc` out 32: current PC, feeds `tao_decode.i_pc`.
- `dec_rdwen` in 1: decoded instruction writes rd.
- `dec_mem_en` in 1: decoded instruction is a load or store.
- `dec_ebreak` in 1: ebreak from the decode info bus.
- `dec_dnpc_en` in 1: taken jump or branch.
- `i_dnpc` in 32: jump or branch target from the EXU.
- `lsu_req_valid` out 1: LSU request.
- `lsu_req_ready` in 1: LSU accepts the request.
- `lsu_rsp_valid` in 1: LSU access complete.
- `o_wb_en` out 1: register-file write strobe.
- `o_retire` out 1: one-cycle pulse per retired instruction.
- `o_halt` out 1: sticky halt.
- `o_err` out 1: sticky error; valid when `o_halt`=1.

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- **IDLE**: entered on reset. Unconditional transition to FETCH_REQ on the next cycle.
- **FETCH_REQ**: `ifu_req_valid`=1. When `ifu_req_ready`=1, go to FETCH_WAIT.
- **FETCH_WAIT**: on `ifu_rsp_valid`=1, load `o_inst`<=`ifu_rsp_inst` and go to EXEC.
  - `ifu_rsp_valid` is ignored in every other state.
- **EXEC**: decode inputs are sampled this cycle, from the latched `o_inst`. Priority order:
  1. `dec_ebreak` -> HALT with `o_err`=0.
  2. `dec_mem_en` -> MEM_REQ.
  3. Otherwise -> WB.
- **MEM_REQ**: `lsu_req_valid`=1. When `lsu_req_ready`=1, go to MEM_WAIT.
- **MEM_WAIT**: on `lsu_rsp_valid`=1, go to WB.
- **WB** (one cycle):
  - `o_wb_en`=`dec_rdwen`; `o_retire`=1.
  - `o_pc`<= `i_dnpc` if `dec_dnpc_en`=1, else `o_pc`+4, wrapping modulo 2^32.
  - Next state FETCH_REQ.
- **Misaligned target**: in WB, if `dec_dnpc_en`=1 and `i_dnpc[1:0]`!=0:
  - go to HALT with `o_err`=1;
  - `o_pc` is not updated; `o_wb_en`=0; `o_retire`=0.
- **Timeout**:
  - A wait counter clears on every state change and increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT.
  - When the counter reaches `TIMEOUT` without the exit condition, go to HALT with `o_err`=1.
  - The counter saturates and never wraps.
- **HALT**: absorbing state. All request outputs are 0, `o_halt`=1, and `o_pc`/`o_inst` are frozen. Only `rst` leaves HALT.
- `dec_*` inputs are consumed only in EXEC and WB; their values in other states are don't-care.

## Timing
- Reset values: state IDLE, `o_pc`=`RESET_PC`, `o_inst`=0, counter 0. All 1-bit outputs are 0 (`ifu_req_valid`, `lsu_req_valid`, `o_wb_en`, `o_retire`, `o_halt`, `o_err`).
- `rst` asserted in any state, including mid-handshake or in HALT, takes effect at the next edge. Any outstanding request is dropped, and a late response after reset is ignored, because the FSM is not in FETCH_WAIT.
- All outputs are registered or decoded from the state register only. No combinational path runs from `*_ready` or `*_rsp_valid` to any output.
- Best-case non-memory instruction (ready=1, response one cycle after acceptance) takes 4 cycles: FETCH_REQ, FETCH_WAIT, EXEC, WB.
- Best-case memory instruction takes 6 cycles.
- The first `ifu_req_valid` appears in the 2nd cycle after `rst` deasserts.
- `o_wb_en`/`o_retire` and the PC update occur in the same cycle, exactly once per instruction.
- The new `o_pc` is visible on `ifu_req_addr` in the following FETCH_REQ cycle.
- `ifu_req_valid` and `lsu_req_valid` stay asserted until accepted, or until timeout.

## Test plan
- **Sequential fetch.** Reset release; memory with ready=1, 1-cycle response returns an addi (x1=x0+5) at 0x8000_0000.
  - `ifu_req_addr`=0x8000_0000 in cycle 2.
  - `o_wb_en`=1 and `o_retire`=1 in cycle 5.
  - Next request address is 0x8000_0004.
- **Jump.** EXU drives `dec_dnpc_en`=1, `i_dnpc`=0x8000_0100 with `dec_rdwen`=1.
  - Write strobe fires.
  - Next `ifu_req_addr`=0x8000_0100.
- **Load with backpressure.** `dec_mem_en`=1; `lsu_req_ready` held 0 for 3 cycles, then 1; response 2 cycles later.
  - `lsu_req_valid` is held for 4 cycles.
  - WB occurs 1 cycle after `lsu_rsp_valid`.
  - Exactly one `o_retire` pulse.
- **Ebreak.** `dec_ebreak`=1 in EXEC.
  - `o_halt`=1, `o_err`=0 on the next cycle, with no `o_retire`.
  - Further `ifu_rsp_valid` pulses leave `o_inst` unchanged.
- **Fault halts.** `TIMEOUT`=8 with `ifu_req_ready` stuck at 0.
  - `o_halt`=`o_err`=1 after 8 FETCH_REQ cycles.
  - Separately, `i_dnpc`=0x8000_0102 with `dec_dnpc_en`=1 -> `o_err`=1 and `o_pc` unchanged.
- **Mid-fetch reset.** `rst` pulsed while in FETCH_WAIT; a stale `ifu_rsp_valid` arrives 1 cycle after reset deasserts.
  - `o_inst` stays 0.
  - `o_pc`=`RESET_PC`.
  - A fresh fetch is issued 2 cycles after `rst` deasserts.

Source files
------------

// File: rtl/tao_seq.sv
// Multi-cycle instruction sequencer for the tao core: owns PC and instruction
// register, runs the fetch and LSU handshakes, and issues writeback/retire.
module tao_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        dec_rdwen,
    input  logic        dec_mem_en,
    input  logic        dec_ebreak,
    input  logic        dec_dnpc_en,
    input  logic [31:0] i_dnpc,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        o_wb_en,
    output logic        o_retire,
    output logic        o_halt,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic [15:0] wait_cnt_reg;
    logic        err_reg;

    logic        in_wait;
    logic        wait_exit;
    logic [15:0] wait_cnt_next;
    logic        timed_out;
    logic        misaligned;

    // Exit condition of whichever handshake state we are in.
    always_comb begin
        in_wait   = 1'b0;
        wait_exit = 1'b0;
        case (state_reg)
            S_FETCH_REQ:  begin in_wait = 1'b1; wait_exit = ifu_req_ready; end
            S_FETCH_WAIT: begin in_wait = 1'b1; wait_exit = ifu_rsp_valid; end
            S_MEM_REQ:    begin in_wait = 1'b1; wait_exit = lsu_req_ready; end
            S_MEM_WAIT:   begin in_wait = 1'b1; wait_exit = lsu_rsp_valid; end
            default:      begin in_wait = 1'b0; wait_exit = 1'b0; end
        endcase
    end

    assign wait_cnt_next = (wait_cnt_reg == 16'hFFFF) ? wait_cnt_reg : wait_cnt_reg + 16'd1;
    assign timed_out     = in_wait && !wait_exit && (wait_cnt_next >= TIMEOUT_C);
    assign misaligned    = (state_reg == S_WB) && dec_dnpc_en && (i_dnpc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            pc_reg       <= RESET_PC;
            inst_reg     <= 32'd0;
            wait_cnt_reg <= 16'd0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: state_reg <= S_FETCH_REQ;
                S_FETCH_REQ: begin
                    if (ifu_req_ready) state_reg <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (ifu_rsp_valid) begin
                        inst_reg  <= ifu_rsp_inst;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dec_ebreak)      state_reg <= S_HALT;
                    else if (dec_mem_en) state_reg <= S_MEM_REQ;
                    else                 state_reg <= S_WB;
                end
                S_MEM_REQ: begin
                    if (lsu_req_ready) state_reg <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (lsu_rsp_valid) state_reg <= S_WB;
                end
                S_WB: begin
                    if (misaligned) begin
                        err_reg   <= 1'b1;
                        state_reg <= S_HALT;
                    end else begin
                        pc_reg    <= dec_dnpc_en ? i_dnpc : pc_reg + 32'd4;
                        state_reg <= S_FETCH_REQ;
                    end
                end
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_IDLE;
            endcase

            // Timeout overrides the normal transition of a stuck handshake.
            if (timed_out) begin
                err_reg   <= 1'b1;
                state_reg <= S_HALT;
            end

            if (in_wait && !wait_exit && !timed_out)
                wait_cnt_reg <= wait_cnt_next;
            else
                wait_cnt_reg <= 16'd0;
        end
    end

    assign ifu_req_valid = (state_reg == S_FETCH_REQ);
    assign lsu_req_valid = (state_reg == S_MEM_REQ);
    assign ifu_req_addr  = pc_reg;
    assign o_pc          = pc_reg;
    assign o_inst        = inst_reg;
    assign o_halt        = (state_reg == S_HALT);
    assign o_err         = err_reg;
    // Strobes depend only on the state register and decode/EXU info, never on handshakes.
    assign o_retire      = (state_reg == S_WB) && !misaligned;
    assign o_wb_en       = (state_reg == S_WB) && dec_rdwen && !misaligned;

endmodule

// File: tb/tb_tao_seq.sv
// Bench for tao_seq: directed scenarios plus randomized instruction streams
// checked against an instruction-level PC/latency model.
module tb_tao_seq;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_inst;
    logic [31:0] o_inst, o_pc, i_dnpc;
    logic        dec_rdwen, dec_mem_en, dec_ebreak, dec_dnpc_en;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic        o_wb_en, o_retire, o_halt, o_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_pc;

    tao_seq #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst(ifu_rsp_inst), .o_inst(o_inst), .o_pc(o_pc),
        .dec_rdwen(dec_rdwen), .dec_mem_en(dec_mem_en), .dec_ebreak(dec_ebreak),
        .dec_dnpc_en(dec_dnpc_en), .i_dnpc(i_dnpc),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .o_wb_en(o_wb_en), .o_retire(o_retire),
        .o_halt(o_halt), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'd0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
        dec_rdwen = 1'b0; dec_mem_en = 1'b0; dec_ebreak = 1'b0; dec_dnpc_en = 1'b0;
        i_dnpc = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_pc", o_pc, RPC);
        chk("rst_inst", o_inst, 32'd0);
        chk("rst_flags", {26'd0, ifu_req_valid, lsu_req_valid, o_wb_en, o_retire, o_halt, o_err}, 32'd0);
        rst = 1'b0;
        model_pc = RPC;
        @(negedge clk);
        chk("first_req", ifu_req_valid, 1'b1);
    endtask

    // One instruction from its FETCH_REQ cycle through WB (or halt).
    task automatic do_instr(input logic [31:0] inst, input logic rdw, input logic mem,
                            input logic ebk, input logic jmp, input logic [31:0] tgt,
                            input int fd, input int rd, input int md, input int ld,
                            output logic halted);
        logic mis;
        mis = jmp && (tgt[1:0] != 2'b00);
        halted = 1'b0;
        dec_rdwen = rdw; dec_mem_en = mem; dec_ebreak = ebk; dec_dnpc_en = jmp; i_dnpc = tgt;
        chk("fetch_addr", ifu_req_addr, model_pc);
        for (int i = 0; i <= fd; i++) begin
            chk("ifu_req_valid", ifu_req_valid, 1'b1);
            ifu_req_ready = (i == fd);
            @(negedge clk);
        end
        ifu_req_ready = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            chk("ifu_req_drop", ifu_req_valid, 1'b0);
            ifu_rsp_valid = (i == rd);
            ifu_rsp_inst  = (i == rd) ? inst : $urandom;
            @(negedge clk);
        end
        ifu_rsp_valid = 1'b0;
        chk("o_inst", o_inst, inst);
        chk("exec_retire", o_retire, 1'b0);
        @(negedge clk);
        if (ebk) begin
            chk("ebrk_halt", o_halt, 1'b1);
            chk("ebrk_err", o_err, 1'b0);
            chk("ebrk_retire", o_retire, 1'b0);
            halted = 1'b1;
        end else begin
            if (mem) begin
                for (int i = 0; i <= md; i++) begin
                    chk("lsu_req_valid", lsu_req_valid, 1'b1);
                    lsu_req_ready = (i == md);
                    @(negedge clk);
                end
                lsu_req_ready = 1'b0;
                for (int i = 0; i <= ld; i++) begin
                    chk("lsu_req_drop", lsu_req_valid, 1'b0);
                    lsu_rsp_valid = (i == ld);
                    @(negedge clk);
                end
                lsu_rsp_valid = 1'b0;
            end
            if (mis) begin
                chk("mis_retire", o_retire, 1'b0);
                chk("mis_wb_en", o_wb_en, 1'b0);
                @(negedge clk);
                chk("mis_halt", o_halt, 1'b1);
                chk("mis_err", o_err, 1'b1);
                chk("mis_pc", o_pc, model_pc);
                halted = 1'b1;
            end else begin
                chk("wb_retire", o_retire, 1'b1);
                chk("wb_en", o_wb_en, rdw);
                model_pc = jmp ? tgt : model_pc + 32'd4;
                @(negedge clk);
                chk("retire_once", o_retire, 1'b0);
                chk("next_pc", o_pc, model_pc);
                chk("refetch", ifu_req_valid, 1'b1);
            end
        end
    endtask

    // HALT must stay frozen regardless of stray responses.
    task automatic after_halt(input logic exp_err);
        logic [31:0] inst_hold, pc_hold;
        inst_hold = o_inst;
        pc_hold   = o_pc;
        for (int i = 0; i < 3; i++) begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_inst  = $urandom;
            lsu_req_ready = 1'b1;
            @(negedge clk);
            chk("halt_inst", o_inst, inst_hold);
            chk("halt_pc", o_pc, pc_hold);
            chk("halt_state", {28'd0, o_halt, o_err, ifu_req_valid, lsu_req_valid},
                {28'd0, 1'b1, exp_err, 1'b0, 1'b0});
        end
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
    endtask

    initial begin
        logic        h;
        int          cnt;
        int          r;
        logic        ebk, jmp, mem, rdw;
        logic [31:0] tgt;

        do_reset();
        do_instr(32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0, h);
        do_instr(32'h0fc0_006f, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0100, 0, 0, 0, 0, h);
        do_instr(32'h0000_a103, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 0, 0, 3, 1, h);
        do_instr(32'h0010_0073, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1, 1, 0, 0, h);
        after_halt(1'b0);

        // Fetch request never accepted.
        do_reset();
        cnt = 0;
        while (!o_halt && cnt < 40) begin
            if (ifu_req_valid) cnt++;
            @(negedge clk);
        end
        chk("timeout_cycles", cnt, TO);
        chk("timeout_halt", o_halt, 1'b1);
        chk("timeout_err", o_err, 1'b1);

        do_reset();
        do_instr(32'h1020_006f, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0102, 0, 0, 0, 0, h);
        after_halt(1'b1);

        // Reset while waiting for a fetch response, then a stale response.
        do_reset();
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        chk("mid_fetch_wait", ifu_req_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'hdead_beef;
        @(negedge clk);
        chk("mid_refetch", ifu_req_valid, 1'b1);
        chk("mid_pc", o_pc, RPC);
        chk("mid_inst", o_inst, 32'd0);
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        chk("mid_inst_late", o_inst, 32'd0);

        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int k = 0; k < 25; k++) begin
                r   = $urandom_range(0, 19);
                ebk = (r == 0);
                jmp = ($urandom_range(0, 2) == 0);
                mem = $urandom_range(0, 1) == 1;
                rdw = $urandom_range(0, 1) == 1;
                tgt = $urandom & 32'hFFFF_FFFC;
                if (r == 1) tgt = tgt | 32'($urandom_range(1, 3));
                do_instr($urandom, rdw, mem, ebk, jmp, tgt,
                         $urandom_range(0, 5), $urandom_range(0, 5),
                         $urandom_range(0, 5), $urandom_range(0, 5), h);
                if (h) begin
                    after_halt(!ebk);
                    break;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
